// File: rtl/dmem_ctrl.sv
// Data-memory controller: one core load/store request at a time, driven onto a single-port sync SRAM.
// Latency: grant in cycle 0, SRAM access in cycle WAIT_STATES+1, rvalid in cycle WAIT_STATES+2.
// Backpressure: data_gnt_o follows data_req_i only in IDLE; the core holds req until it is granted.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned or illegal byte-enable requests get an error response.
// The optional check skips the SRAM and responds one cycle after grant.
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_be_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Counter preload; WAIT_STATES is at most 3, so two bits suffice.
  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  grant;
  logic                  req_illegal;

  // Address bits outside the SRAM word index are dropped, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};

  assign grant = (state_q == S_IDLE) && data_req_i;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;

  // Classify the incoming request: only naturally aligned byte, half and word enables are legal.
  always_comb begin
    req_illegal = 1'b1;
    case (data_be_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: req_illegal = 1'b0;
      4'b0011, 4'b1100:                   req_illegal = data_addr_i[0];
      4'b1111:                            req_illegal = |data_addr_i[1:0];
      default:                            req_illegal = 1'b1;
    endcase
  end

  // Error flag captured at grant and presented during the response.
  always_comb begin
    err_d = err_q;
    if (grant) begin
      err_d = req_illegal;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign req_illegal = 1'b0;
`endif

  // Next state, wait counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          addr_d  = data_addr_i[ADDR_WIDTH+1:2];
          we_d    = data_we_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          if (req_illegal) begin
            state_d = S_RESP;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-request registers; reset drops any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Output decode: SRAM signals only while the access is issued, response only in RESP.
  always_comb begin
    data_gnt_o    = grant;
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    data_err_o    = 1'b0;
    sram_cs_o     = 1'b0;
    sram_we_o     = 1'b0;
    sram_be_o     = 4'h0;
    sram_addr_o   = '0;
    sram_wdata_o  = 32'h0;
    case (state_q)
      S_ACCESS: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = we_q;
        sram_be_o    = we_q ? be_q : 4'hF;
        sram_addr_o  = addr_q;
        sram_wdata_o = wdata_q;
      end
      S_RESP: begin
        data_rvalid_o = 1'b1;
        // Read data is a straight pass of the macro output, no extra register stage.
        data_rdata_o  = we_q ? 32'h0 : sram_rdata_i;
`ifdef DMEM_ALIGN_CHECK_EN
        if (err_q) begin
          data_rdata_o = 32'h0;
          data_err_o   = 1'b1;
        end
`endif
      end
      default: begin
      end
    endcase
  end

endmodule
